axis_bram_packet_writer: RTL and testbench

Parametrised AXI4-Stream to BRAM packet writer, successor to the single-buffer stream writer in the PCIe completer-request path. Accepts one framed packet (terminated by `t_last`) per start command, writes each accepted beat to a simple-dual-port BRAM with per-byte write enables, and reports beat/byte counts and overflow on completion. Supports a configurable base address and a selectable wrap or drop policy at the end of the buffer.

---
 rtl/axis_bram_packet_writer.sv | 168 ++++++++++++++++
 tb/tb_axis_bram_packet_writer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_packet_writer.sv
// axis_bram_packet_writer
// Accepts one t_last-framed AXI4-Stream packet per start command and writes
// each accepted beat into a simple-dual-port BRAM (per-byte write enables),
// starting at a programmable base address with wrap or drop handling at the
// end of the buffer. Beat/byte counts and overflow are reported on completion.
//
// Optional feature macro: AXIS_WR_BYTE_COUNT_EN
//   defined   -> popcount adder built, pkt_bytes counts kept bytes
//   undefined -> pkt_bytes tied to zero, no popcount logic

module axis_bram_packet_writer #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                                      axis_clk,
    input  logic                                      reset_n,
    input  logic                                      start,
    input  logic [ADDR_WIDTH-1:0]                     base_addr,
    input  logic                                      wrap_mode,
    input  logic                                      t_valid,
    output logic                                      t_ready,
    input  logic [DATA_WIDTH-1:0]                     t_data,
    input  logic [KEEP_WIDTH-1:0]                     t_keep,
    input  logic                                      t_last,
    output logic                                      bram_ena,
    output logic [KEEP_WIDTH-1:0]                     bram_wena,
    output logic [ADDR_WIDTH-1:0]                     bram_address,
    output logic [DATA_WIDTH-1:0]                     bram_data,
    output logic                                      busy,
    output logic                                      pkt_done,
    output logic [ADDR_WIDTH:0]                       pkt_beats,
    output logic [ADDR_WIDTH+$clog2(KEEP_WIDTH):0]    pkt_bytes,
    output logic                                      overflow
);

    localparam int                    BYTES_W   = ADDR_WIDTH + $clog2(KEEP_WIDTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP,
        DONE
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic                    wrap_en;
    // Set once the last buffer word has been written in drop mode; the next
    // beat has nowhere to go and is treated as overflow.
    logic                    full;
    logic                    arm;
    logic                    accept;
    logic                    write_beat;
    logic [DATA_WIDTH-1:0]   masked_data;

    // Control decodes come from registered state only, so t_ready has no
    // combinational path from t_valid.
    assign t_ready    = (state == RECV) || (state == DROP);
    assign busy       = (state != IDLE);
    assign pkt_done   = (state == DONE);
    assign arm        = (state == IDLE) && start;
    assign accept     = t_valid && t_ready;
    assign write_beat = accept && (state == RECV) && !full;

    // Zero every byte lane whose keep bit is clear before it reaches the BRAM.
    always_comb begin
        masked_data = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            masked_data[i*8 +: 8] = t_keep[i] ? t_data[i*8 +: 8] : 8'h00;
        end
    end

    // Packet FSM with registered BRAM write port, pointer and beat counter.
    always_ff @(posedge axis_clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ptr          <= '0;
            wrap_en      <= 1'b0;
            full         <= 1'b0;
            bram_ena     <= 1'b0;
            bram_wena    <= '0;
            bram_address <= '0;
            bram_data    <= '0;
            pkt_beats    <= '0;
            overflow     <= 1'b0;
        end else begin
            bram_ena  <= 1'b0;
            bram_wena <= '0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        ptr       <= base_addr;
                        wrap_en   <= wrap_mode;
                        full      <= 1'b0;
                        pkt_beats <= '0;
                        overflow  <= 1'b0;
                        state     <= RECV;
                    end
                end
                RECV: begin
                    if (accept) begin
                        if (full) begin
                            overflow <= 1'b1;
                            state    <= t_last ? DONE : DROP;
                        end else begin
                            bram_ena     <= 1'b1;
                            bram_wena    <= t_keep;
                            bram_address <= ptr;
                            bram_data    <= masked_data;
                            pkt_beats    <= pkt_beats + 1'b1;
                            if (ptr == LAST_ADDR) begin
                                if (wrap_en) begin
                                    ptr <= '0;
                                end else begin
                                    full <= 1'b1;
                                end
                            end else begin
                                ptr <= ptr + 1'b1;
                            end
                            if (t_last) begin
                                state <= DONE;
                            end
                        end
                    end
                end
                DROP: begin
                    if (accept && t_last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef AXIS_WR_BYTE_COUNT_EN
    function automatic logic [BYTES_W-1:0] keep_popcount(input logic [KEEP_WIDTH-1:0] keep);
        logic [BYTES_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            cnt = cnt + BYTES_W'(keep[i]);
        end
        return cnt;
    endfunction

    // Kept-byte accumulator, advancing only on beats that reach the BRAM.
    always_ff @(posedge axis_clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_bytes <= '0;
        end else if (arm) begin
            pkt_bytes <= '0;
        end else if (write_beat) begin
            pkt_bytes <= pkt_bytes + keep_popcount(t_keep);
        end
    end
`else
    assign pkt_bytes = '0;
`endif

endmodule

// File: tb/tb_axis_bram_packet_writer.sv
// Directed bench for axis_bram_packet_writer (32-bit data, 16-word buffer).
module tb_axis_bram_packet_writer;

    localparam int DW = 32;
    localparam int KW = 4;
    localparam int AW = 4;

`ifdef AXIS_WR_BYTE_COUNT_EN
    localparam bit BYTE_CNT = 1'b1;
`else
    localparam bit BYTE_CNT = 1'b0;
`endif

    logic          axis_clk;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          wrap_mode;
    logic          t_valid;
    logic          t_ready;
    logic [DW-1:0] t_data;
    logic [KW-1:0] t_keep;
    logic          t_last;
    logic          bram_ena;
    logic [KW-1:0] bram_wena;
    logic [AW-1:0] bram_address;
    logic [DW-1:0] bram_data;
    logic          busy;
    logic          pkt_done;
    logic [AW:0]   pkt_beats;
    logic [6:0]    pkt_bytes;
    logic          overflow;

    int n_cmp;
    int n_err;

    axis_bram_packet_writer #(
        .DATA_WIDTH(DW),
        .KEEP_WIDTH(KW),
        .ADDR_WIDTH(AW),
        .DEPTH     (16)
    ) dut (
        .axis_clk    (axis_clk),
        .reset_n     (reset_n),
        .start       (start),
        .base_addr   (base_addr),
        .wrap_mode   (wrap_mode),
        .t_valid     (t_valid),
        .t_ready     (t_ready),
        .t_data      (t_data),
        .t_keep      (t_keep),
        .t_last      (t_last),
        .bram_ena    (bram_ena),
        .bram_wena   (bram_wena),
        .bram_address(bram_address),
        .bram_data   (bram_data),
        .busy        (busy),
        .pkt_done    (pkt_done),
        .pkt_beats   (pkt_beats),
        .pkt_bytes   (pkt_bytes),
        .overflow    (overflow)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_bytes(input int n);
        return BYTE_CNT ? 64'(n) : 64'd0;
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic wrap, input string tag);
        start     = 1'b1;
        base_addr = base;
        wrap_mode = wrap;
        step();
        start     = 1'b0;
        check({tag, ".ready"}, 64'(t_ready), 64'd1);
        check({tag, ".busy"},  64'(busy),    64'd1);
    endtask

    // Present one beat for a single cycle and check the registered BRAM port afterwards.
    task automatic send(input logic [DW-1:0] data, input logic [KW-1:0] keep, input logic last,
                        input logic exp_ena, input logic [AW-1:0] exp_addr,
                        input logic [DW-1:0] exp_data, input string tag);
        check({tag, ".rdy_in"}, 64'(t_ready), 64'd1);
        t_valid = 1'b1;
        t_data  = data;
        t_keep  = keep;
        t_last  = last;
        step();
        t_valid = 1'b0;
        t_last  = 1'b0;
        check({tag, ".ena"},  64'(bram_ena),  64'(exp_ena));
        check({tag, ".wena"}, 64'(bram_wena), exp_ena ? 64'(keep) : 64'd0);
        if (exp_ena) begin
            check({tag, ".addr"}, 64'(bram_address), 64'(exp_addr));
            check({tag, ".data"}, 64'(bram_data),    64'(exp_data));
        end
    endtask

    task automatic check_done(input int beats, input int bytes, input logic ovf, input string tag);
        check({tag, ".done"},  64'(pkt_done),  64'd1);
        check({tag, ".ready"}, 64'(t_ready),   64'd0);
        check({tag, ".beats"}, 64'(pkt_beats), 64'(beats));
        check({tag, ".bytes"}, 64'(pkt_bytes), exp_bytes(bytes));
        check({tag, ".ovf"},   64'(overflow),  64'(ovf));
        step();
        check({tag, ".done_off"}, 64'(pkt_done), 64'd0);
        check({tag, ".idle"},     64'(busy),     64'd0);
        check({tag, ".beats_hold"}, 64'(pkt_beats), 64'(beats));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"}, 64'(t_ready),      64'd0);
        check({tag, ".ena"},   64'(bram_ena),     64'd0);
        check({tag, ".wena"},  64'(bram_wena),    64'd0);
        check({tag, ".addr"},  64'(bram_address), 64'd0);
        check({tag, ".data"},  64'(bram_data),    64'd0);
        check({tag, ".busy"},  64'(busy),         64'd0);
        check({tag, ".done"},  64'(pkt_done),     64'd0);
        check({tag, ".beats"}, 64'(pkt_beats),    64'd0);
        check({tag, ".bytes"}, 64'(pkt_bytes),    64'd0);
        check({tag, ".ovf"},   64'(overflow),     64'd0);
    endtask

    task automatic basic_packet(input logic [DW-1:0] first, input string tag);
        do_start(4'd0, 1'b0, tag);
        for (int i = 0; i < 4; i++) begin
            send(first + DW'(i), 4'hF, (i == 3), 1'b1, AW'(i), first + DW'(i),
                 $sformatf("%s.b%0d", tag, i));
        end
        check_done(4, 16, 1'b0, tag);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        wrap_mode = 1'b0;
        t_valid   = 1'b0;
        t_data    = '0;
        t_keep    = '0;
        t_last    = 1'b0;
        step();
        step();
        check_reset_outputs("rst");
        reset_n = 1'b1;
        step();
        check_reset_outputs("post_rst");

        // Basic four-beat packet from address 0.
        basic_packet(32'hA0, "basic");

        // Single beat with bytes 0 and 2 kept.
        do_start(4'd5, 1'b0, "partial");
        send(32'h1122_3344, 4'b0101, 1'b1, 1'b1, 4'd5, 32'h0022_0044, "partial.b0");
        check_done(1, 2, 1'b0, "partial");

        // Wrap from the top of the buffer back to 0.
        do_start(4'd14, 1'b1, "wrap");
        send(32'hD0, 4'hF, 1'b0, 1'b1, 4'd14, 32'hD0, "wrap.b0");
        send(32'hD1, 4'hF, 1'b0, 1'b1, 4'd15, 32'hD1, "wrap.b1");
        send(32'hD2, 4'hF, 1'b0, 1'b1, 4'd0,  32'hD2, "wrap.b2");
        send(32'hD3, 4'hF, 1'b1, 1'b1, 4'd1,  32'hD3, "wrap.b3");
        check_done(4, 16, 1'b0, "wrap");

        // Drop mode: only two words fit, remaining beats are swallowed.
        do_start(4'd14, 1'b0, "drop");
        send(32'hE0, 4'hF, 1'b0, 1'b1, 4'd14, 32'hE0, "drop.b0");
        send(32'hE1, 4'hF, 1'b0, 1'b1, 4'd15, 32'hE1, "drop.b1");
        send(32'hE2, 4'hF, 1'b0, 1'b0, 4'd0,  32'h0,  "drop.b2");
        check("drop.ovf_early", 64'(overflow), 64'd1);
        send(32'hE3, 4'hF, 1'b0, 1'b0, 4'd0,  32'h0,  "drop.b3");
        send(32'hE4, 4'hF, 1'b1, 1'b0, 4'd0,  32'h0,  "drop.b4");
        check_done(2, 8, 1'b1, "drop");

        // Gaps in t_valid, including a zero-keep beat.
        do_start(4'd0, 1'b0, "gaps");
        send(32'hC0, 4'hF, 1'b0, 1'b1, 4'd0, 32'hC0, "gaps.b0");
        step();
        check("gaps.idle0", 64'(bram_ena), 64'd0);
        send(32'hC1, 4'h0, 1'b0, 1'b1, 4'd1, 32'h0, "gaps.b1");
        step();
        check("gaps.idle1", 64'(bram_ena), 64'd0);
        send(32'hC2, 4'hF, 1'b1, 1'b1, 4'd2, 32'hC2, "gaps.b2");
        check_done(3, 8, 1'b0, "gaps");

        // Reset after two of four beats.
        do_start(4'd0, 1'b0, "midrst");
        send(32'hF0, 4'hF, 1'b0, 1'b1, 4'd0, 32'hF0, "midrst.b0");
        send(32'hF1, 4'hF, 1'b0, 1'b1, 4'd1, 32'hF1, "midrst.b1");
        t_valid = 1'b1;
        t_data  = 32'hF2;
        t_keep  = 4'hF;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst.async");
        step();
        check_reset_outputs("midrst.hold");
        reset_n = 1'b1;
        t_data  = 32'hF3;
        t_last  = 1'b1;
        step();
        check("midrst.no_write", 64'(bram_ena), 64'd0);
        check("midrst.idle",     64'(busy),     64'd0);
        t_valid = 1'b0;
        t_last  = 1'b0;
        step();
        basic_packet(32'hB0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
